// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, leaf count, source-tag field position
// and the round-robin pick helper used by the cluster uplink.
package noc_pkg;

  localparam int FLIT_W     = 20;
  localparam int LEAF_N     = 4;
  localparam int LEAF_ID_W  = 2;
  localparam int SRCTAG_MSB = 19;
  localparam int SRCTAG_LSB = 18;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic                 found;
    logic [LEAF_ID_W-1:0] idx;
  } grant_t;

  // Search starts at the leaf after 'last' and wraps once around all leaves.
  function automatic grant_t rr_pick(input logic [LEAF_N-1:0] req,
                                     input logic [LEAF_ID_W-1:0] last);
    grant_t               g;
    logic [LEAF_ID_W-1:0] idx;
    g = '0;
    for (int i = 1; i <= LEAF_N; i++) begin
      idx = last + LEAF_ID_W'(i);
      if (!g.found && req[idx]) begin
        g.found = 1'b1;
        g.idx   = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/uplink_fifo.sv
// Per-leaf flit FIFO; extra pointer MSB distinguishes full from empty on wrap.
// Write acceptance policy (full-but-popping) is decided by the caller.
module uplink_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  flit_t wr_data,
  input  logic  rd_en,
  output flit_t rd_data,
  output logic  empty,
  output logic  full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  flit_t       mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cluster_uplink.sv
// Four-leaf uplink: per-leaf FIFOs, credit-gated round-robin arbiter, two-stage
// registered output. Define CLUSTER_UPLINK_SRCTAG_EN to stamp the leaf id into the flit.
module cluster_uplink
  import noc_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  flit_t             in_leaf0,
  input  flit_t             in_leaf1,
  input  flit_t             in_leaf2,
  input  flit_t             in_leaf3,
  input  logic              v_leaf0,
  input  logic              v_leaf1,
  input  logic              v_leaf2,
  input  logic              v_leaf3,
  output logic [LEAF_N-1:0] cred_leaf,
  output flit_t             sd_out,
  output logic              sd_out_valid,
  input  logic              cred_up,
  output logic [LEAF_N-1:0] err_ovf
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  flit_t                leaf_in [LEAF_N];
  flit_t                head    [LEAF_N];
  logic [LEAF_N-1:0]    v_vec, empty, full, wr_en, pop, ovf;
  logic [3:0]           credit_cnt;
  logic [LEAF_ID_W-1:0] rr_ptr;
  grant_t               gr;
  logic                 grant_vld;
  flit_t                grant_flit;

  // Pipeline stage between FIFO pop and the registered output.
  logic                 pipe_vld;
  flit_t                pipe_flit;
  logic [LEAF_ID_W-1:0] pipe_idx;

  assign leaf_in[0] = in_leaf0;
  assign leaf_in[1] = in_leaf1;
  assign leaf_in[2] = in_leaf2;
  assign leaf_in[3] = in_leaf3;
  assign v_vec      = {v_leaf3, v_leaf2, v_leaf1, v_leaf0};

  // A full FIFO still accepts when it is popped on the same edge.
  assign wr_en = v_vec & (~full | pop);
  assign ovf   = v_vec & full & ~pop;

  for (genvar g = 0; g < LEAF_N; g++) begin : g_fifo
    uplink_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[g]),
      .wr_data (leaf_in[g]),
      .rd_en   (pop[g]),
      .rd_data (head[g]),
      .empty   (empty[g]),
      .full    (full[g])
    );
  end

  always_comb begin
    gr         = rr_pick(~empty, rr_ptr);
    grant_vld  = gr.found && (credit_cnt != '0);
    pop        = grant_vld ? (LEAF_N'(1) << gr.idx) : '0;
    grant_flit = head[gr.idx];
`ifdef CLUSTER_UPLINK_SRCTAG_EN
    grant_flit[SRCTAG_MSB:SRCTAG_LSB] = gr.idx;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt   <= CRED_MAX;
      rr_ptr       <= LEAF_ID_W'(LEAF_N - 1);
      err_ovf      <= '0;
      pipe_vld     <= 1'b0;
      pipe_flit    <= '0;
      pipe_idx     <= '0;
      sd_out       <= '0;
      sd_out_valid <= 1'b0;
      cred_leaf    <= '0;
    end else begin
      err_ovf <= err_ovf | ovf;

      // Grant consumes one credit, cred_up returns one; both together cancel.
      if (grant_vld && !cred_up)
        credit_cnt <= credit_cnt - 1'b1;
      else if (!grant_vld && cred_up && credit_cnt < CRED_MAX)
        credit_cnt <= credit_cnt + 1'b1;

      pipe_vld <= grant_vld;
      if (grant_vld) begin
        pipe_flit <= grant_flit;
        pipe_idx  <= gr.idx;
        rr_ptr    <= gr.idx;
      end

      sd_out_valid <= pipe_vld;
      if (pipe_vld) sd_out <= pipe_flit;
      cred_leaf <= pipe_vld ? (LEAF_N'(1) << pipe_idx) : '0;
    end
  end

endmodule
